// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring step: subtract the divisor from the partial remainder and keep the
// difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // One extra bit beyond the partial remainder acts as the borrow/sign of the trial.
  logic [WIDTH+1:0] trial;

  assign trial    = {1'b0, partial} - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/restoring_div.sv
// Sequential radix-2 restoring divider: 2W/W -> W quotient and W remainder, one
// quotient bit per clock behind a start/busy/done handshake.
module restoring_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvsr;
  logic             err_pend;

  logic             last_iter;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_shifted;

  // The dividend's low half doubles as the quotient register: its MSB shifts into the
  // partial remainder while the new quotient bit enters at the bottom.
  assign partial   = {rem_reg, q_reg[WIDTH-1]};
  assign q_shifted = {q_reg[WIDTH-2:0], step_q};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial  (partial),
    .divisor  (dvsr),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (err_pend || last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A high half >= divisor cannot yield a W-bit quotient (and catches divisor=0),
  // so such operations skip iteration and complete as errors on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem_reg   <= '0;
      q_reg     <= '0;
      dvsr      <= '0;
      err_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvsr     <= divisor;
            rem_reg  <= dividend[2*WIDTH-1:WIDTH];
            q_reg    <= dividend[WIDTH-1:0];
            cnt      <= '0;
            err_pend <= (dividend[2*WIDTH-1:WIDTH] >= divisor);
            busy     <= 1'b1;
            err      <= 1'b0;
          end
        end
        RUN: begin
          if (err_pend) begin
            err_pend  <= 1'b0;
            quotient  <= '1;
            remainder <= '0;
            err       <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rem_reg <= step_rem;
            q_reg   <= q_shifted;
            cnt     <= cnt + 1'b1;
            if (last_iter) begin
              cnt       <= '0;
              quotient  <= q_shifted;
              remainder <= step_rem;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div.sv
// Directed bench for restoring_div: arithmetic, errors, handshake, reset abort and
// multiplier-style regression vectors.
module tb_restoring_div;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy, done, err;
  logic [W-1:0]  quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  restoring_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] dd, input logic [15:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int lat, output int busyCnt);
    lat = 0;
    busyCnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busyCnt++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic runCheck(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                          input logic [15:0] expQ, input logic [15:0] expR,
                          input logic expErr, input int expLat);
    int lat, busyCnt;
    applyStimulus(dd, dv);
    waitDone(tag, lat, busyCnt);
    checkOutput({tag, "_lat"},  32'(lat),       32'(expLat));
    checkOutput({tag, "_busy"}, 32'(busyCnt),   32'(expLat));
    checkOutput({tag, "_q"},    32'(quotient),  32'(expQ));
    checkOutput({tag, "_r"},    32'(remainder), 32'(expR));
    checkOutput({tag, "_err"},  32'(err),       32'(expErr));
  endtask

  logic [31:0] regX [8] = '{32'h1234, 32'hFFFF, 32'h0001, 32'hABCD,
                            32'h8000, 32'h0000, 32'h7FFF, 32'h00FF};
  logic [31:0] regY [8] = '{32'h0056, 32'h0001, 32'hFFFF, 32'h1357,
                            32'h8000, 32'h0003, 32'hFFFE, 32'h0100};

  initial begin
    int lat, lat2, busyCnt, doneCount;
    logic [31:0] rr;

    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err",  32'(err),  32'd0);
    checkOutput("rst_q",    32'(quotient),  32'd0);
    checkOutput("rst_r",    32'(remainder), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runCheck("basic",  32'd100,      16'd7,      16'd14,     16'd2,      1'b0, W);
    runCheck("max0",   32'hFFFE0001, 16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, W);
    runCheck("maxR",   32'hFFFEFFFF, 16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b0, W);
    runCheck("div0",   32'h00001234, 16'h0000,   16'hFFFF,   16'h0000,   1'b1, 1);
    runCheck("ovf",    32'h00070000, 16'h0007,   16'hFFFF,   16'h0000,   1'b1, 1);

    // A start at cycle 5 of a run must be ignored.
    applyStimulus(32'd100, 16'd7);
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    dividend = 32'hFFFE0001;
    divisor  = 16'hFFFF;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    checkOutput("ign_lat", 32'(lat), 32'(W));
    checkOutput("ign_q",   32'(quotient),  32'd14);
    checkOutput("ign_r",   32'(remainder), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ign_idle", 32'(busy), 32'd0);

    // start held high: second accept in the done cycle, done-to-done is W+1.
    @(negedge clk);
    dividend = 32'hFFFEFFFF;
    divisor  = 16'hFFFF;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    checkOutput("hold1_lat", 32'(lat), 32'(W));
    checkOutput("hold1_q", 32'(quotient),  32'hFFFF);
    checkOutput("hold1_r", 32'(remainder), 32'hFFFE);
    dividend = 32'd1000;
    divisor  = 16'd10;
    lat2 = 0;
    do begin @(posedge clk); #1; lat2++; end while (!done && lat2 < 40);
    start = 1'b0;
    checkOutput("hold2_gap", 32'(lat2), 32'(W + 1));
    checkOutput("hold2_q", 32'(quotient),  32'd100);
    checkOutput("hold2_r", 32'(remainder), 32'd0);

    // Asynchronous reset at cycle 8 of a run aborts without a done.
    applyStimulus(32'd100, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err",  32'(err),  32'd0);
    checkOutput("abort_q",    32'(quotient),  32'd0);
    checkOutput("abort_r",    32'(remainder), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (20) begin @(posedge clk); #1; if (done) doneCount++; end
    checkOutput("abort_nodone", 32'(doneCount), 32'd0);
    runCheck("post_rst", 32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, W);

    // Multiplier-format vectors: X*Y+R with R<Y divides back to X rem R.
    for (int i = 0; i < 8; i++) begin
      rr = (regY[i] > 1) ? 32'($urandom_range(int'(regY[i]) - 1, 0)) : 32'd0;
      runCheck($sformatf("reg%0d", i), regX[i] * regY[i] + rr, regY[i][15:0],
               regX[i][15:0], rr[15:0], 1'b0, W);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
